fetch_sequencer: RTL

//  Instruction-fetch controller for the EC413 pipelined CPU. Owns the PC, drives the word-indexed
//  PC into the combinational instruction memory and captures its output into the IF/ID register.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_if_id_reg.sv | 31 +++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch slice: PC width, NOP encoding
// and the fetch controller state encoding.
package fetch_sequencer_pkg;

  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // BOOT: one idle cycle after reset before the first fetch
  // RUN:  normal fetch, PC still inside the program
  // DRAIN: PC has run past the last instruction, pipeline emptying
  // DONE: program finished, absorbing until reset
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+1 and valid bit.
// Priority is reset > clear > load > hold; clear inserts a NOP bubble.
module if_id_reg
  import fetch_sequencer_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic [PC_W-1:0] instr_d,
  input  logic [PC_W-1:0] pc1_d,
  input  logic            valid_d,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc1,
  output logic            valid
);

  // Register update: bubble on reset/clear, capture on load, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      instr <= NOP_INSTR;
      pc1   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc1   <= pc1_d;
      valid <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, feeds the combinational
// instruction memory, fills the IF/ID register, applies stalls and EX-stage
// redirects, and detects end of program so the pipeline can drain.
//
// Control semantics: redirect_valid is a single-cycle qualifier for
// redirect_pc and is acted on in the same cycle it is high (no ready/backpressure;
// redirect always wins over stall). stall is a level that holds PC and IF/ID
// for every cycle it is high.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PROG_LENGTH = 50,
  parameter int DRAIN_CYC   = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc1,
  output logic             ifid_valid,
  output logic             flush_idex,
  output logic             done,
  output logic [CNT_W-1:0] fetch_count,
  output fetch_state_t     fsm_state
);

  localparam int              DW         = $clog2(DRAIN_CYC + 1);
  localparam logic [PC_W-1:0] LAST_PC    = PC_W'(PROG_LENGTH);
  localparam logic [DW-1:0]   DRAIN_DONE = DW'(DRAIN_CYC);

  fetch_state_t     state, state_n;
  logic [PC_W-1:0]  pc_reg, pc_n, pc_inc;
  logic [DW-1:0]    drain_cnt, drain_n;
  logic [CNT_W-1:0] count_n;
  logic             ifid_load, ifid_clear, ifid_valid_d, fetch_ok;

  // State, PC and counter registers; reset discards everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_BOOT;
      pc_reg      <= '0;
      drain_cnt   <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc_reg      <= pc_n;
      drain_cnt   <= drain_n;
      fetch_count <= count_n;
    end
  end

  // Next-state, PC mux and IF/ID control: redirect > stall > advance.
  always_comb begin
    state_n      = state;
    pc_n         = pc_reg;
    drain_n      = drain_cnt;
    count_n      = fetch_count;
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    ifid_valid_d = 1'b0;
    pc_inc       = pc_reg + PC_W'(1);
    fetch_ok     = (pc_reg <= LAST_PC);

    case (state)
      S_BOOT: begin
        state_n = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          ifid_clear = 1'b1;
          drain_n    = '0;
          state_n    = (redirect_pc <= LAST_PC) ? S_RUN : S_DRAIN;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_valid_d = fetch_ok;
          pc_n         = pc_inc;
          if (fetch_ok && (fetch_count != {CNT_W{1'b1}})) begin
            count_n = fetch_count + CNT_W'(1);
          end
          if (state == S_DRAIN) begin
            drain_n = drain_cnt + DW'(1);
            if (drain_n == DRAIN_DONE) begin
              state_n = S_DONE;
            end
          end else if (pc_inc == LAST_PC + PC_W'(1)) begin
            state_n = S_DRAIN;
          end
        end
      end
      S_DONE: begin
        ifid_clear = 1'b1;
      end
      default: begin
        state_n = S_BOOT;
      end
    endcase
  end

  if_id_reg u_if_id (
    .clock   (clock),
    .reset   (reset),
    .clear   (ifid_clear),
    .load    (ifid_load),
    .instr_d (imem_instr),
    .pc1_d   (pc_inc),
    .valid_d (ifid_valid_d),
    .instr   (ifid_instr),
    .pc1     (ifid_pc1),
    .valid   (ifid_valid)
  );

  assign imem_pc    = pc_reg;
  assign flush_idex = redirect_valid && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign fsm_state  = state;

endmodule
